// File: rtl/video_clkgen.sv
// rtl/video_clkgen.sv - multi-channel programmable clock divider with phase alignment and lock flag
module video_clkgen #(
  parameter int                        NUM_CLKS    = 3,
  parameter int                        DIV_W       = 8,
  parameter logic [NUM_CLKS*DIV_W-1:0] DIV_INIT    = {8'd2, 8'd2, 8'd2},
  parameter int                        LOCK_CYCLES = 16
) (
  input  logic                                            refclk,
  input  logic                                            rst_n,
  input  logic                                            cfg_valid,
  output logic                                            cfg_ready,
  input  logic [(NUM_CLKS > 1 ? $clog2(NUM_CLKS) : 1)-1:0] cfg_chan,
  input  logic [DIV_W-1:0]                                cfg_div,
  input  logic [DIV_W-1:0]                                cfg_phase,
  output logic [NUM_CLKS-1:0]                             outclk,
  output logic [NUM_CLKS-1:0]                             outclk_en,
  output logic                                            locked
);

  localparam int CW = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1;
  localparam int SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {S_RESET, S_ALIGN, S_SETTLE, S_LOCKED} state_t;

  state_t            r_state;
  logic [SW-1:0]     r_settle;
  logic [DIV_W-1:0]  r_div   [NUM_CLKS];
  logic [DIV_W-1:0]  r_phase [NUM_CLKS];
  logic [DIV_W-1:0]  r_cnt   [NUM_CLKS];

  logic [DIV_W-1:0]  w_cnt_next [NUM_CLKS];
  logic [DIV_W-1:0]  w_hi       [NUM_CLKS];
  logic [NUM_CLKS-1:0] w_run_clk, w_run_en, w_align_clk, w_align_en;
  logic [DIV_W-1:0]  w_eff_div, w_eff_phase;
  logic              w_chan_ok, w_accept;

  always_comb begin
    for (int i = 0; i < NUM_CLKS; i++) begin
      w_cnt_next[i]  = (r_cnt[i] == r_div[i] - DIV_W'(1)) ? '0 : r_cnt[i] + DIV_W'(1);
      w_hi[i]        = DIV_W'(({1'b0, r_div[i]} + (DIV_W+1)'(1)) >> 1);
      w_run_clk[i]   = (w_cnt_next[i] < w_hi[i]);
      w_run_en[i]    = (w_cnt_next[i] == '0);
      w_align_clk[i] = (r_phase[i] < w_hi[i]);
      w_align_en[i]  = (r_phase[i] == '0);
    end
    // Degenerate ratios are forced to 2 and the phase must land inside the period.
    w_eff_div   = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    w_eff_phase = (cfg_phase >= w_eff_div) ? '0 : cfg_phase;
    w_chan_ok   = (int'(cfg_chan) < NUM_CLKS);
    w_accept    = cfg_valid && cfg_ready;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state   <= S_RESET;
      r_settle  <= '0;
      outclk    <= '0;
      outclk_en <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      for (int i = 0; i < NUM_CLKS; i++) begin
        r_div[i]   <= DIV_INIT[i*DIV_W +: DIV_W];
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      case (r_state)
        S_RESET: begin
          r_state <= S_ALIGN;
        end
        S_ALIGN: begin
          r_state   <= S_SETTLE;
          r_settle  <= '0;
          outclk    <= w_align_clk;
          outclk_en <= w_align_en;
          for (int i = 0; i < NUM_CLKS; i++) r_cnt[i] <= r_phase[i];
        end
        S_SETTLE: begin
          outclk    <= w_run_clk;
          outclk_en <= w_run_en;
          for (int i = 0; i < NUM_CLKS; i++) r_cnt[i] <= w_cnt_next[i];
          if (r_settle == SW'(LOCK_CYCLES - 1)) begin
            r_state   <= S_LOCKED;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        S_LOCKED: begin
          // Out-of-range targets complete the handshake but leave everything running.
          if (w_accept && w_chan_ok) begin
            r_state   <= S_ALIGN;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            outclk    <= '0;
            outclk_en <= '0;
            for (int i = 0; i < NUM_CLKS; i++) begin
              if (cfg_chan == CW'(i)) begin
                r_div[i]   <= w_eff_div;
                r_phase[i] <= w_eff_phase;
              end
            end
          end else begin
            outclk    <= w_run_clk;
            outclk_en <= w_run_en;
            for (int i = 0; i < NUM_CLKS; i++) r_cnt[i] <= w_cnt_next[i];
          end
        end
        default: r_state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_video_clkgen.sv
// tb/tb_video_clkgen.sv - directed self-checking bench for video_clkgen
module tb_video_clkgen;

  localparam int LOCK = 16;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_phase = '0;
  logic [2:0] outclk, outclk_en;
  logic       locked;

  int n_cmp = 0;
  int n_err = 0;
  int m_div [3];
  int m_phase [3];
  int m_k;

  video_clkgen dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
    m_k++;
  endtask

  function automatic logic [2:0] exp_clk(input int k);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (((m_phase[i] + k) % m_div[i]) < ((m_div[i] + 1) / 2));
    return r;
  endfunction

  function automatic logic [2:0] exp_en(input int k);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (((m_phase[i] + k) % m_div[i]) == 0);
    return r;
  endfunction

  task automatic defaults();
    for (int i = 0; i < 3; i++) begin
      m_div[i] = 2;
      m_phase[i] = 0;
    end
  endtask

  // From the ALIGN state: restart edge, then lock after LOCK more edges.
  task automatic settle_seq(input string tag);
    step();
    m_k = 0;
    chk({tag, "_restart_clk"}, outclk, exp_clk(0));
    chk({tag, "_restart_en"}, outclk_en, exp_en(0));
    for (int j = 1; j <= LOCK; j++) begin
      step();
      chk({tag, "_clk"}, outclk, exp_clk(m_k));
      chk({tag, "_en"}, outclk_en, exp_en(m_k));
      chk({tag, "_locked"}, locked, (j == LOCK));
      chk({tag, "_ready"}, cfg_ready, (j == LOCK));
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      step();
      chk({tag, "_clk"}, outclk, exp_clk(m_k));
      chk({tag, "_en"}, outclk_en, exp_en(m_k));
      chk({tag, "_locked"}, locked, 1);
    end
  endtask

  task automatic accept_cfg(input string tag, input int ch, input int dv, input int ph);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_div   = 8'(dv);
    cfg_phase = 8'(ph);
    step();
    cfg_valid = 1'b0;
    chk({tag, "_acc_locked"}, locked, 0);
    chk({tag, "_acc_ready"}, cfg_ready, 0);
    chk({tag, "_acc_clk"}, outclk, 0);
  endtask

  logic [4:0] pat5;
  logic [7:0] h0, h1, e0, e1;
  logic       found;

  initial begin
    defaults();
    m_k = 0;

    // Reset state
    repeat (3) step();
    chk("rst_clk", outclk, 0);
    chk("rst_en", outclk_en, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", cfg_ready, 0);

    // Reset release with defaults
    rst_n = 1'b1;
    step();
    chk("e0_clk", outclk, 0);
    chk("e0_locked", locked, 0);
    settle_seq("boot");
    run("boot_run", 4);

    // Odd divide: chan 2 div 5 -> high 3 / low 2
    accept_cfg("odd", 2, 5, 0);
    m_div[2] = 5;
    settle_seq("odd");
    found = 1'b0;
    for (int j = 0; j < 10 && !found; j++) begin
      step();
      found = outclk_en[2];
    end
    chk("odd_en_found", found, 1);
    pat5 = 5'b00111;
    for (int j = 0; j < 5; j++) begin
      chk("odd_pattern", outclk[2], pat5[j]);
      step();
    end

    // Phase offset: chan 0 div 4, chan 1 div 4 phase 2
    accept_cfg("ph0", 0, 4, 0);
    m_div[0] = 4;
    settle_seq("ph0");
    accept_cfg("ph1", 1, 4, 2);
    m_div[1] = 4;
    m_phase[1] = 2;
    settle_seq("ph1");
    for (int j = 0; j < 8; j++) begin
      step();
      h0[j] = outclk[0];
      h1[j] = outclk[1];
      e0[j] = outclk_en[0];
      e1[j] = outclk_en[1];
    end
    for (int j = 2; j < 8; j++) begin
      chk("phase_delay_clk", h1[j], h0[j-2]);
      chk("phase_delay_en", e1[j], e0[j-2]);
    end

    // Illegal values
    accept_cfg("div1", 1, 1, 0);
    m_div[1] = 2;
    m_phase[1] = 0;
    settle_seq("div1");
    accept_cfg("ph9", 2, 6, 9);
    m_div[2] = 6;
    m_phase[2] = 0;
    settle_seq("ph9");
    cfg_valid = 1'b1;
    cfg_chan = 2'd3;
    cfg_div = 8'd7;
    cfg_phase = 8'd1;
    step();
    cfg_valid = 1'b0;
    chk("oor_locked", locked, 1);
    chk("oor_ready", cfg_ready, 1);
    chk("oor_clk", outclk, exp_clk(m_k));
    run("oor_run", 6);

    // Request held through SETTLE is taken on the first LOCKED cycle only
    cfg_valid = 1'b1;
    cfg_chan = 2'd0;
    cfg_div = 8'd3;
    cfg_phase = 8'd1;
    step();
    chk("hold_acc_locked", locked, 0);
    m_div[0] = 3;
    m_phase[0] = 1;
    cfg_chan = 2'd1;
    cfg_div = 8'd3;
    cfg_phase = 8'd0;
    settle_seq("hold");
    step();
    cfg_valid = 1'b0;
    chk("hold2_acc_locked", locked, 0);
    chk("hold2_acc_clk", outclk, 0);
    m_div[1] = 3;
    m_phase[1] = 0;
    settle_seq("hold2");

    // Reset wins over a simultaneous request
    cfg_valid = 1'b1;
    cfg_chan = 2'd2;
    cfg_div = 8'd9;
    cfg_phase = 8'd0;
    rst_n = 1'b0;
    step();
    cfg_valid = 1'b0;
    chk("prio_locked", locked, 0);
    chk("prio_clk", outclk, 0);
    chk("prio_ready", cfg_ready, 0);
    rst_n = 1'b1;
    step();
    chk("prio_e0_clk", outclk, 0);
    defaults();
    settle_seq("prio");

    // Reset mid-SETTLE: low at E8 and E9, released at E10
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int j = 1; j <= 7; j++) step();
    chk("mid_e7_locked", locked, 0);
    rst_n = 1'b0;
    step();
    chk("mid_e8_clk", outclk, 0);
    chk("mid_e8_en", outclk_en, 0);
    chk("mid_e8_locked", locked, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_e0_clk", outclk, 0);
    settle_seq("mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/video_clkgen.md
# video_clkgen

Parametrised multi-channel clock generator for the video subsystem. From a single reference clock it produces `NUM_CLKS` divided clocks, each with its own programmable integer divide ratio and phase offset, plus per-channel rising-edge enables. All channels realign on every reconfiguration. A `locked` flag marks the outputs as stable after a settle interval. It serves pixel and peripheral clock domains and can be retuned at run time without a full device reset.

## Interface

Parameters:
- `NUM_CLKS`, 3: number of output channels, 1..8.
- `DIV_W`, 8: width of the divide and phase fields.
- `DIV_INIT`, {8'd2, 8'd2, 8'd2}: packed reset divide ratios, `NUM_CLKS*DIV_W` bits, channel 0 in the LSBs.
- `LOCK_CYCLES`, 16: settle length in cycles, at least 1.

Ports:
- `refclk`, in, 1: sole clock. All logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cfg_valid`, in, 1: reconfiguration request.
- `cfg_ready`, out, 1: block can accept a request.
- `cfg_chan`, in, `max(1,$clog2(NUM_CLKS))`: target channel.
- `cfg_div`, in, `DIV_W`: new divide ratio.
- `cfg_phase`, in, `DIV_W`: new phase offset, in `refclk` cycles.
- `outclk`, out, `NUM_CLKS`: divided clocks, registered.
- `outclk_en`, out, `NUM_CLKS`: one-cycle pulse in the cycle where the corresponding `outclk` rises.
- `locked`, out, 1: outputs stable.

## Operation

State machine: RESET → ALIGN → SETTLE → LOCKED.
- **RESET:** `rst_n` is low at the edge.
  - `outclk`, `outclk_en`, `locked` and `cfg_ready` are all 0.
  - `div_i` is loaded from `DIV_INIT`; `phase_i` is set to 0.
- **ALIGN:** lasts one cycle. All outputs are 0. Each channel position `c_i` is loaded with `phase_i`.
- **SETTLE:** channels run. `locked` stays 0. Lasts `LOCK_CYCLES` cycles, then moves to LOCKED.
- **LOCKED:** channels run, `locked` is 1, `cfg_ready` is 1.

Channel behaviour, in SETTLE and LOCKED:
- `c_i` increments modulo `div_i` every cycle.
- `hi_i = ceil(div_i/2)`.
- `outclk[i]` is 1 exactly when `c_i < hi_i`.
  - Even divide ratios give a 50% duty cycle.
  - Odd divide ratios are high one cycle longer than they are low.
- `outclk_en[i]` is 1 exactly when `c_i == 0`.

Reconfiguration:
- A request is accepted when `cfg_valid && cfg_ready` at an edge, which can only happen in LOCKED.
- Write rules for channel `cfg_chan`:
  - `cfg_div` of 0 or 1 is clamped to 2.
  - If `cfg_phase >= ` the effective divide ratio, the phase is written as 0.
  - Both the divide ratio and the phase are written.
- At the same edge the state moves to ALIGN: `locked` and `cfg_ready` drop, and all channels realign.
- Out-of-range target: if `cfg_chan >= NUM_CLKS`, the request is accepted and discarded. No write, no realignment, `locked` stays 1.

Priority and interrupted sequences:
- Reset takes priority over everything, including a simultaneous `cfg_valid`.
- Reset asserted mid-SETTLE or mid-ALIGN returns the block to RESET and restores `DIV_INIT`.
- `cfg_valid` outside LOCKED is ignored. The requester must hold the request until `cfg_ready` is 1.

## Timing

- Let E0 be the first edge with `rst_n` high.
  - The block is in ALIGN after E0 and in SETTLE after E1.
  - `locked` rises at edge E(1+`LOCK_CYCLES`), which is E17 by default.
- The first channel values (`c_i = phase_i`) are visible after E1.
  - A channel with phase 0 has `outclk` high and `outclk_en` high after E1.
- A request accepted at edge A:
  - `locked`, `cfg_ready` and `outclk` are 0 after A.
  - Channels restart after A+1.
  - `locked` returns at A+1+`LOCK_CYCLES`.
- Outputs are glitch-free: each is driven directly from a flop.
- Phase relation: channels with equal divide ratios and phases differing by p are offset by exactly p cycles.

## Test plan

- **Reset release, defaults:** release `rst_n` → all three `outclk` toggle 1,0,1,0 in phase starting at E1. `outclk_en` pulses every 2 cycles. `locked` is 0 through E16 and 1 from E17. `cfg_ready` tracks `locked`.
- **Odd divide:** write chan 2, div 5, phase 0 → `locked` falls for 17 cycles. `outclk[2]` then repeats high 3 / low 2. Channels 0 and 1 realign at A+1.
- **Phase offset:** write chan 0 div 4, then chan 1 div 4 phase 2 → `outclk[1]` is `outclk[0]` delayed by exactly 2 cycles. `outclk_en[1]` is 2 cycles after `outclk_en[0]`.
- **Illegal values:**
  - div 1 → clamped to 2.
  - div 6 phase 9 → phase written as 0.
  - `cfg_chan` 3 (with `NUM_CLKS` 3) → handshake completes and `locked` never drops.
- **Handshake and priority:**
  - `cfg_valid` held during SETTLE → accepted only on the first LOCKED cycle.
  - `cfg_valid` with `rst_n` low at the same edge → request dropped and `DIV_INIT` restored.
- **Reset mid-SETTLE:** assert `rst_n` low at E8, release at E10 → all outputs are 0 after E8. `locked` rises 17 edges after the new E0.
